// File: rtl/lerp_pipe_if.sv
// Handshake bundle for lerp_pipe: an input side (operands and tag)
// and an output side (result and tag), each with valid/ready.
interface lerp_pipe_if #(
    parameter int INPUT_BITS      = 16,
    parameter int RATIO_FRAC_BITS = 8,
    parameter int CHAN_BITS       = 3
);
    logic                       in_valid;
    logic                       in_ready;
    logic [INPUT_BITS-1:0]      ina;
    logic [INPUT_BITS-1:0]      inb;
    logic [RATIO_FRAC_BITS-1:0] ratio;
    logic [CHAN_BITS-1:0]       in_chan;
    logic                       out_valid;
    logic                       out_ready;
    logic [INPUT_BITS-1:0]      out;
    logic [CHAN_BITS-1:0]       out_chan;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid, ina, inb, ratio, in_chan, out_ready,
        input  in_ready, out_valid, out, out_chan
    );

    // The interpolator itself
    modport slave (
        input  in_valid, ina, inb, ratio, in_chan, out_ready,
        output in_ready, out_valid, out, out_chan
    );
endinterface

// File: rtl/lerp_pipe.sv
// Three-stage linear interpolator: out = inb + ((ina - inb) * ratio) >> r,
// with optional round-half-up. Each stage has its own valid flag and
// advances when empty or when the stage after it advances, so bubbles
// collapse and a full pipe keeps streaming while out_ready is high.
module lerp_pipe #(
    parameter int INPUT_BITS      = 16,
    parameter int RATIO_FRAC_BITS = 8,
    parameter int CHAN_BITS       = 3,
    parameter int ROUND           = 0
) (
    input  logic         clk,
    input  logic         reset,
    lerp_pipe_if.slave   bus
);
    localparam int AW = INPUT_BITS + 1;                    // difference width
    localparam int BW = INPUT_BITS + RATIO_FRAC_BITS + 1;  // product width

    // Half an LSB of the result, added before the shift when rounding
    localparam logic [BW-1:0] RND_BIAS = (ROUND != 0)
        ? ({{(BW-1){1'b0}}, 1'b1} << (RATIO_FRAC_BITS - 1))
        : '0;

    // Stage 1: difference, low endpoint, ratio, tag
    logic                       s1_valid_reg;
    logic signed [AW-1:0]       s1_a_reg;
    logic [INPUT_BITS-1:0]      s1_lo_reg;
    logic [RATIO_FRAC_BITS-1:0] s1_ratio_reg;
    logic [CHAN_BITS-1:0]       s1_chan_reg;

    // Stage 2: exact product, low endpoint, tag
    logic                       s2_valid_reg;
    logic signed [BW-1:0]       s2_b_reg;
    logic [INPUT_BITS-1:0]      s2_lo_reg;
    logic [CHAN_BITS-1:0]       s2_chan_reg;

    // Stage 3: final result and tag
    logic                       s3_valid_reg;
    logic [INPUT_BITS-1:0]      s3_out_reg;
    logic [CHAN_BITS-1:0]       s3_chan_reg;

    logic adv1, adv2, adv3;
    logic in_fire;

    logic signed [AW-1:0]  a_next;
    logic signed [BW-1:0]  a_ext;
    logic signed [BW-1:0]  ratio_ext;
    logic signed [BW-1:0]  b_next;
    logic signed [BW-1:0]  b_rnd;
    logic [INPUT_BITS-1:0] out_next;

    // Backpressure chain: a stage moves when empty or when its successor moves
    assign adv3 = ~s3_valid_reg | bus.out_ready;
    assign adv2 = ~s2_valid_reg | adv3;
    assign adv1 = ~s1_valid_reg | adv2;

    assign bus.in_ready = adv1 & ~reset;
    assign in_fire      = bus.in_valid & bus.in_ready;

    // Arithmetic between stages; the product is exact at BW bits
    assign a_next    = $signed({1'b0, bus.ina}) - $signed({1'b0, bus.inb});
    assign a_ext     = {{(BW-AW){s1_a_reg[AW-1]}}, s1_a_reg};
    assign ratio_ext = {{(BW-RATIO_FRAC_BITS){1'b0}}, s1_ratio_reg};
    assign b_next    = a_ext * ratio_ext;
    assign b_rnd     = s2_b_reg + $signed(RND_BIAS);
    assign out_next  = INPUT_BITS'(b_rnd >>> RATIO_FRAC_BITS) + s2_lo_reg;

    // Outputs are forced to zero whenever no result is held
    assign bus.out_valid = s3_valid_reg;
    assign bus.out       = s3_valid_reg ? s3_out_reg  : '0;
    assign bus.out_chan  = s3_valid_reg ? s3_chan_reg : '0;

    // Stage 1: capture the accepted operands and their difference
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_lo_reg    <= '0;
            s1_ratio_reg <= '0;
            s1_chan_reg  <= '0;
        end else if (adv1) begin
            s1_valid_reg <= in_fire;
            if (in_fire) begin
                s1_a_reg     <= a_next;
                s1_lo_reg    <= bus.inb;
                s1_ratio_reg <= bus.ratio;
                s1_chan_reg  <= bus.in_chan;
            end
        end
    end

    // Stage 2: scale the difference by the ratio
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            s2_b_reg     <= '0;
            s2_lo_reg    <= '0;
            s2_chan_reg  <= '0;
        end else if (adv2) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_b_reg    <= b_next;
                s2_lo_reg   <= s1_lo_reg;
                s2_chan_reg <= s1_chan_reg;
            end
        end
    end

    // Stage 3: drop the fraction, add back the low endpoint, hold while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid_reg <= 1'b0;
            s3_out_reg   <= '0;
            s3_chan_reg  <= '0;
        end else if (adv3) begin
            s3_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                s3_out_reg  <= out_next;
                s3_chan_reg <= s2_chan_reg;
            end
        end
    end
endmodule

// File: tb/tb_lerp_pipe.sv
// Bench for lerp_pipe: two instances (truncate and round) share one
// stimulus stream; a scoreboard predicts results from the interpolation
// formula and checks handshake, ordering, stall hold and reset behaviour.
module tb_lerp_pipe;
    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [15:0] ina       = '0;
    logic [15:0] inb       = '0;
    logic [7:0]  ratio     = '0;
    logic [2:0]  in_chan   = '0;
    logic        out_ready = 1'b1;

    // Side information travelling with each stimulus transaction
    bit          has_lit   = 1'b0;
    logic [15:0] lit0      = '0;
    logic [15:0] lit1      = '0;
    bit          lat_mode  = 1'b0;
    bit          end_req   = 1'b0;

    logic        rdy_w [2];
    logic        ov_w  [2];
    logic [15:0] o_w   [2];
    logic [2:0]  oc_w  [2];

    always #5 clk = ~clk;

    // Instance 0 truncates, instance 1 rounds half up
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        lerp_pipe_if #(.INPUT_BITS(16), .RATIO_FRAC_BITS(8), .CHAN_BITS(3)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.ina       = ina;
        assign bus.inb       = inb;
        assign bus.ratio     = ratio;
        assign bus.in_chan   = in_chan;
        assign bus.out_ready = out_ready;
        lerp_pipe #(
            .INPUT_BITS(16), .RATIO_FRAC_BITS(8), .CHAN_BITS(3), .ROUND(gi)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
        assign rdy_w[gi] = bus.in_ready;
        assign ov_w[gi]  = bus.out_valid;
        assign o_w[gi]   = bus.out;
        assign oc_w[gi]  = bus.out_chan;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  r;
        logic [2:0]  c;
        bit          hl;
        logic [15:0] l0;
        logic [15:0] l1;
        bit          cl;
        int          cyc;
    } txn_t;

    txn_t        hist [2][1024];
    int          wr [2] = '{0, 0};
    int          rd [2] = '{0, 0};
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          hold   [2] = '{1'b0, 1'b0};
    logic [15:0] hold_o [2];
    logic [2:0]  hold_c [2];

    // Interpolation in plain integer arithmetic with floor division
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [7:0] r, input int rnd);
        longint num, q;
        num = (longint'(a) - longint'(b)) * longint'(r) + ((rnd != 0) ? 128 : 0);
        if (num >= 0) q = num / 256;
        else          q = -((-num + 255) / 256);
        return 16'(q + longint'(b));
    endfunction

    task automatic check(input string nm, input int d, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d got 0x%0h want 0x%0h (cycle %0d)", nm, d, got, want, cyc);
        end
    endtask

    // Single compare process, sampling on the falling edge
    always @(negedge clk) begin
        int          inflight;
        txn_t        t;
        logic [15:0] lo, hi, e;
        cyc++;
        if (cyc == 2) begin
            check("model_pin_a", 0, model(16'h1000, 16'h0000, 8'h80, 0), 16'h0800);
            check("model_pin_b", 0, model(16'h0000, 16'hFFFF, 8'h80, 0), 16'h7FFF);
            check("model_pin_c", 1, model(16'h0000, 16'hFFFF, 8'h80, 1), 16'h8000);
            check("model_pin_d", 1, model(16'hFFFF, 16'h0000, 8'hFF, 1), 16'hFEFF);
        end
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                check("rst_out_valid", d, ov_w[d], 0);
                check("rst_out", d, o_w[d], 0);
                check("rst_out_chan", d, oc_w[d], 0);
                check("rst_in_ready", d, rdy_w[d], 0);
                rd[d]   = wr[d];
                hold[d] = 1'b0;
            end else begin
                inflight = wr[d] - rd[d];
                check("in_ready", d, rdy_w[d], (inflight < 3 || out_ready));
                if (hold[d]) begin
                    check("stall_valid", d, ov_w[d], 1);
                    check("stall_out", d, o_w[d], hold_o[d]);
                    check("stall_chan", d, oc_w[d], hold_c[d]);
                end
                if (ov_w[d]) begin
                    if (inflight == 0) begin
                        check("stale_result", d, ov_w[d], 0);
                    end else if (out_ready) begin
                        t = hist[d][rd[d] % 1024];
                        rd[d]++;
                        e = model(t.a, t.b, t.r, d);
                        check("out", d, o_w[d], e);
                        check("out_chan", d, oc_w[d], t.c);
                        lo = (t.a < t.b) ? t.a : t.b;
                        hi = (t.a < t.b) ? t.b : t.a;
                        check("range", d, (o_w[d] >= lo && o_w[d] <= hi), 1);
                        if (t.hl) check("literal", d, o_w[d], (d == 0) ? t.l0 : t.l1);
                        if (t.cl) check("latency", d, cyc - t.cyc, 3);
                    end
                end
                hold[d]   = ov_w[d] && !out_ready;
                hold_o[d] = o_w[d];
                hold_c[d] = oc_w[d];
                if (in_valid && rdy_w[d]) begin
                    hist[d][wr[d] % 1024] = '{a: ina, b: inb, r: ratio, c: in_chan,
                                              hl: has_lit, l0: lit0, l1: lit1,
                                              cl: lat_mode, cyc: cyc};
                    wr[d]++;
                end
                if (end_req) check("drained", d, wr[d] - rd[d], 0);
            end
        end
    end

    // Offer one transaction and hold it until accepted (bounded wait)
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [7:0] r,
                        input logic [2:0] c, input bit hl, input logic [15:0] l0,
                        input logic [15:0] l1);
        int n;
        in_valid = 1'b1;
        ina = a; inb = b; ratio = r; in_chan = c;
        has_lit = hl; lit0 = l0; lit1 = l1;
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy_w[0]) break;
            n++;
            if (n > 50) begin
                $display("FAIL send_timeout in_ready stuck low got 0 want 1");
                $fatal(1, "send timeout");
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        has_lit  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] dir_a  [7] = '{16'h1000, 16'h0000, 16'hFFFF, 16'h5555, 16'hABCD, 16'h0000, 16'h0003};
    logic [15:0] dir_b  [7] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h1234, 16'hABCD, 16'h0100, 16'h0000};
    logic [7:0]  dir_r  [7] = '{8'h80, 8'h80, 8'hFF, 8'h00, 8'hC3, 8'hFF, 8'h80};
    logic [15:0] dir_l0 [7] = '{16'h0800, 16'h7FFF, 16'hFEFF, 16'h1234, 16'hABCD, 16'h0001, 16'h0001};
    logic [15:0] dir_l1 [7] = '{16'h0800, 16'h8000, 16'hFEFF, 16'h1234, 16'hABCD, 16'h0001, 16'h0002};

    initial begin
        logic [15:0] ra, rb;
        logic [7:0]  rr;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        idle(1);

        // Directed vectors, one at a time, latency must be exactly 3
        lat_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(dir_a[i], dir_b[i], dir_r[i], 3'(i), 1'b1, dir_l0[i], dir_l1[i]);
            idle(5);
        end

        // Eight tagged transactions with downstream stalled mid-stream
        lat_mode = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'(i * 16'h1111), 16'(16'hF000 - i * 16'h0321), 8'(i * 37 + 5),
                         3'(i), 1'b0, '0, '0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(10);

        // Continuous stream with downstream always ready
        lat_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rr = 8'($urandom);
            if (i % 10 == 0) rr = 8'h00;
            if (i % 10 == 1) rb = ra;
            send(ra, rb, rr, 3'(i), 1'b0, '0, '0);
        end
        idle(6);

        // Reset with three transactions held behind a stalled output
        lat_mode  = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++)
            send(16'(16'h2000 * i), 16'h0400, 8'h40, 3'(i), 1'b0, '0, '0);
        idle(2);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        out_ready = 1'b1;
        idle(8);

        // Normal operation resumes after reset
        lat_mode = 1'b1;
        send(16'h1000, 16'h0000, 8'h80, 3'd5, 1'b1, 16'h0800, 16'h0800);
        idle(6);

        end_req = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        end_req = 1'b0;
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
